imem_dmem_arbiter: RTL and testbench
====================================

# imem_dmem_arbiter

Single-port memory arbiter that shares one synchronous word-addressed RAM between the instruction fetch stage and the load/store unit. It sits between the fetch stage's 30-bit word address output and the RAM, with the load/store port alongside. Each cycle it grants at most one requester and returns read data one cycle later, tagged to the winner. It also produces the fetch stall condition. Data accesses have fixed priority, bounded by an anti-starvation counter so fetch always makes progress.

## Interface

- STARVE_LIMIT, 4: max consecutive load/store grants while fetch is waiting before fetch is forced through; legal range 1..255
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  30  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_stall  out  1  if_req & ~if_gnt; fetch holds PC and address
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  32  read data to fetch
- ls_req  in  1  load/store request this cycle
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  byte enables for stores; ignored on loads
- ls_addr  in  30  data word address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store request accepted this cycle (combinational)
- ls_rvalid  out  1  ls_rdata valid, loads only (registered)
- ls_rdata  out  32  read data to load/store unit
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_be  out  4  RAM byte enables (4'b0000 on reads)
- mem_addr  out  30  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after a read strobe

## Operation

- Arbitration is combinational from the requests and the streak counter.
  - Only one requester active: that requester is granted.
  - Both active and streak < STARVE_LIMIT: load/store is granted.
  - Both active and streak == STARVE_LIMIT: fetch is granted.
- Streak counter, 8 bit:
  - Increments when ls_gnt & if_req.
  - Clears to 0 when if_gnt, or when if_req is low.
  - Saturates at STARVE_LIMIT and never exceeds it.
- RAM mux follows the grant:
  - Fetch granted: mem_en=1, mem_we=0, mem_be=0, mem_addr=if_addr.
  - Load/store granted: mem_en=1, mem_we=ls_we, mem_be=ls_we?ls_be:0, mem_addr=ls_addr, mem_wdata=ls_wdata.
  - No grant: mem_en=0, mem_we=0, mem_be=0; mem_addr and mem_wdata are don't-care.
- Response owner register, states IDLE / IF_RD / LS_RD:
  - Loaded each cycle: IF_RD if if_gnt; LS_RD if ls_gnt & ~ls_we; else IDLE.
  - if_rvalid = (owner == IF_RD); ls_rvalid = (owner == LS_RD).
- Data paths: if_rdata and ls_rdata both carry mem_rdata unconditionally; consumers qualify with their rvalid.
- Stores produce no response.
- A requester must hold its request and payload stable until it sees its grant.

## Timing

- Grant latency: 0 cycles. A request presented in cycle N is granted in cycle N when arbitration selects it.
- Read latency: a grant in cycle N gives rvalid=1 in cycle N+1, with mem_rdata routed to the owner.
- Back-to-back grants to the same or alternating requesters are legal every cycle; throughput is one access per cycle.
- Reset, with rst high at a posedge:
  - owner=IDLE, streak=0, if_rvalid=0, ls_rvalid=0.
  - While rst is high, if_gnt=0, ls_gnt=0, mem_en=0, mem_we=0.
- Reset mid-operation: a read granted in the cycle rst is asserted produces no rvalid afterwards; the requester must reissue it.
- Simultaneous events:
  - A grant and a response to the same requester in the same cycle is legal; the response belongs to the previous cycle's grant.
  - A streak increment and clear in the same cycle cannot occur, because the grants are exclusive.
- Boundary conditions:
  - With STARVE_LIMIT=1, grants alternate LS, IF, LS, IF under continuous contention.
  - Address wrap is not handled; addresses pass through unchanged.

## Test plan

- Fetch only: after reset, if_req=1 with if_addr = 0x15, 0x16, 0x17 on successive cycles -> if_gnt=1 each cycle, mem_addr follows, if_rvalid=1 one cycle later with RAM contents, if_stall=0.
- Store then load: ls_req store to 0x40, ls_be=4'b0011, wdata=0xDEADBEEF; next cycle load 0x40 over old value 0 -> no ls_rvalid after the store; ls_rdata=0x0000BEEF with ls_rvalid one cycle after the load grant.
- Contention, STARVE_LIMIT=4: both requesting continuously for 10 cycles -> grant pattern LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; if_stall high on each LS cycle.
- Streak clear: both requesting for 3 cycles, then if_req low for 1 cycle, then both again -> the streak restarts at 0, so 4 more LS grants precede the next IF grant.
- Response routing: fetch read granted in cycle N, load granted in cycle N+1 -> if_rvalid only in N+1, ls_rvalid only in N+2, never both in the same cycle.
- Reset mid-read: load granted in the same cycle rst=1 -> ls_rvalid=0 next cycle, all grants 0 while rst is held, normal operation on the first cycle after rst falls.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store
// Load/store has fixed priority; the streak counter forces fetch through after STARVE_LIMIT losses.
module imem_dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_gnt,
  output logic        if_stall,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [29:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD} owner_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  owner_t     owner;
  logic [7:0] streak;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (if_req && (!ls_req || streak >= LIMIT))
        if_gnt = 1'b1;
      else if (ls_req)
        ls_gnt = 1'b1;
    end
  end

  assign if_stall  = if_req & ~if_gnt;

  assign mem_en    = if_gnt | ls_gnt;
  assign mem_we    = ls_gnt & ls_we;
  assign mem_be    = (ls_gnt && ls_we) ? ls_be : 4'b0000;
  assign mem_addr  = if_gnt ? if_addr : ls_addr;
  assign mem_wdata = ls_wdata;

  // Response owner records who was granted a read, so the next cycle's data is tagged correctly.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= IDLE;
      streak <= 8'd0;
    end else begin
      if (if_gnt)
        owner <= IF_RD;
      else if (ls_gnt && !ls_we)
        owner <= LS_RD;
      else
        owner <= IDLE;

      if (if_gnt || !if_req)
        streak <= 8'd0;
      else if (ls_gnt && streak < LIMIT)
        streak <= streak + 8'd1;
    end
  end

  assign if_rvalid = (owner == IF_RD);
  assign ls_rvalid = (owner == LS_RD);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed self-checking bench for imem_dmem_arbiter
// A small byte-enabled synchronous RAM model sits behind the arbiter.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt;
  logic        if_stall;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [29:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int compared;
  int mismatched;

  logic [31:0] ram [0:255];

  imem_dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: word i holds 0xA00000ii, except word 0x40 which starts at zero.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= (i == 8'h40) ? 32'h0 : (32'hA000_0000 | 32'(i));
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] if_pat;
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 30'h15;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 30'h16; ls_wdata = 32'h0;

    cyc(); cyc();
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);

    // Fetch only
    cyc();
    rst = 1'b0; ls_req = 1'b0; if_req = 1'b1; if_addr = 30'h15;
    #1;
    check("f0_if_gnt", 32'(if_gnt), 32'd1);
    check("f0_mem_addr", 32'(mem_addr), 32'h15);
    check("f0_if_stall", 32'(if_stall), 32'd0);
    check("f0_mem_we", 32'(mem_we), 32'd0);
    check("f0_if_rvalid", 32'(if_rvalid), 32'd0);
    cyc();
    if_addr = 30'h16;
    #1;
    check("f1_if_gnt", 32'(if_gnt), 32'd1);
    check("f1_mem_addr", 32'(mem_addr), 32'h16);
    check("f1_if_rvalid", 32'(if_rvalid), 32'd1);
    check("f1_if_rdata", if_rdata, 32'hA000_0015);
    cyc();
    if_addr = 30'h17;
    #1;
    check("f2_mem_addr", 32'(mem_addr), 32'h17);
    check("f2_if_rdata", if_rdata, 32'hA000_0016);

    // Store then load
    cyc();
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 30'h40; ls_wdata = 32'hDEAD_BEEF;
    #1;
    check("f3_if_rvalid", 32'(if_rvalid), 32'd1);
    check("f3_if_rdata", if_rdata, 32'hA000_0017);
    check("st_ls_gnt", 32'(ls_gnt), 32'd1);
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_mem_be", 32'(mem_be), 32'h3);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    ls_we = 1'b0; ls_be = 4'hF;
    #1;
    check("ld_ls_gnt", 32'(ls_gnt), 32'd1);
    check("ld_mem_be", 32'(mem_be), 32'h0);
    check("ld_mem_we", 32'(mem_we), 32'd0);
    check("st_no_rvalid", 32'(ls_rvalid), 32'd0);
    cyc();
    ls_req = 1'b0;
    #1;
    check("ld_ls_rvalid", 32'(ls_rvalid), 32'd1);
    check("ld_ls_rdata", ls_rdata, 32'h0000_BEEF);
    check("idle_mem_en", 32'(mem_en), 32'd0);

    // Contention: IF forced through on cycles 4 and 9
    if_pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if_req = 1'b1; if_addr = 30'h18; ls_req = 1'b1; ls_addr = 30'h41;
      #1;
      check($sformatf("cont%0d_if_gnt", i), 32'(if_gnt), 32'(if_pat[i]));
      check($sformatf("cont%0d_ls_gnt", i), 32'(ls_gnt), 32'(!if_pat[i]));
      check($sformatf("cont%0d_if_stall", i), 32'(if_stall), 32'(!if_pat[i]));
    end

    // Streak clear: 3 LS, one cycle without fetch, then 4 LS before IF
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      check($sformatf("clr_pre%0d_ls_gnt", i), 32'(ls_gnt), 32'd1);
    end
    cyc();
    if_req = 1'b0;
    #1;
    check("clr_gap_ls_gnt", 32'(ls_gnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if_req = 1'b1;
      #1;
      check($sformatf("clr_post%0d_if_gnt", i), 32'(if_gnt), (i == 4) ? 32'd1 : 32'd0);
    end

    // Response routing
    cyc();
    ls_req = 1'b0; if_req = 1'b1; if_addr = 30'h19;
    #1;
    check("rt0_if_gnt", 32'(if_gnt), 32'd1);
    check("rt0_if_rvalid", 32'(if_rvalid), 32'd1);
    check("rt0_if_rdata", if_rdata, 32'hA000_0018);
    cyc();
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 30'h16;
    #1;
    check("rt1_ls_gnt", 32'(ls_gnt), 32'd1);
    check("rt1_if_rvalid", 32'(if_rvalid), 32'd1);
    check("rt1_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("rt1_if_rdata", if_rdata, 32'hA000_0019);
    cyc();
    ls_req = 1'b0;
    #1;
    check("rt2_ls_rvalid", 32'(ls_rvalid), 32'd1);
    check("rt2_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rt2_ls_rdata", ls_rdata, 32'hA000_0016);

    // Reset mid-read
    cyc();
    rst = 1'b1; ls_req = 1'b1; ls_addr = 30'h17;
    #1;
    check("mr0_ls_gnt", 32'(ls_gnt), 32'd0);
    check("mr0_mem_en", 32'(mem_en), 32'd0);
    cyc();
    #1;
    check("mr1_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("mr1_ls_gnt", 32'(ls_gnt), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("mr2_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("mr2_ls_gnt", 32'(ls_gnt), 32'd1);
    check("mr2_mem_addr", 32'(mem_addr), 32'h17);
    cyc();
    ls_req = 1'b0;
    #1;
    check("mr3_ls_rvalid", 32'(ls_rvalid), 32'd1);
    check("mr3_ls_rdata", ls_rdata, 32'hA000_0017);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
